// File: rtl/bench_sequencer.sv
// bench_sequencer: command sequencer driving an accumulator unit.
// Accepts opcode commands and replays their control pattern for N cycles.
module bench_sequencer #(
   parameter int DATA_WIDTH = 8,
   parameter int ATTR_WIDTH = 4,
   parameter int CNT_WIDTH  = 8
) (
   input  logic                  clk,
   input  logic                  RST,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic [2:0]            cmd_op,
   input  logic [DATA_WIDTH-1:0] cmd_data,
   input  logic [ATTR_WIDTH-1:0] cmd_attr,
   input  logic [CNT_WIDTH-1:0]  cmd_count,
   output logic                  signal_load,
   output logic                  signal_init,
   output logic                  signal_neg,
   output logic                  signal_oe,
   output logic [DATA_WIDTH-1:0] data_in_o,
   output logic [ATTR_WIDTH-1:0] attr_in_o,
   output logic                  busy,
   output logic                  cmd_done,
   output logic                  err
);

   typedef enum logic {IDLE, EXEC} state_t;

   localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

   state_t               state;
   state_t               state_nxt;
   logic [CNT_WIDTH-1:0] cnt;
   logic [CNT_WIDTH-1:0] cnt_load;
   logic                 accept;
   logic                 last;
   logic                 dec_load;
   logic                 dec_init;
   logic                 dec_neg;
   logic                 dec_oe;
   logic                 dec_pass;
   logic                 dec_ill;

   assign last   = (state == EXEC) && (cnt == CNT_ONE);
   assign accept = cmd_valid && cmd_ready;

   // Opcode decode into control pattern; illegal codes run as a 1-cycle NOP
   always_comb begin
      dec_load = 1'b0;
      dec_init = 1'b0;
      dec_neg  = 1'b0;
      dec_oe   = 1'b0;
      dec_pass = 1'b0;
      dec_ill  = 1'b0;
      case (cmd_op)
         3'd0: ;
         3'd1: begin
            dec_load = 1'b1;
            dec_init = 1'b1;
            dec_pass = 1'b1;
         end
         3'd2: begin
            dec_load = 1'b1;
            dec_pass = 1'b1;
         end
         3'd3: begin
            dec_neg  = 1'b1;
            dec_pass = 1'b1;
         end
         3'd4: dec_oe = 1'b1;
         3'd5: begin
            dec_load = 1'b1;
            dec_neg  = 1'b1;
            dec_pass = 1'b1;
         end
         default: dec_ill = 1'b1;
      endcase
      if (dec_ill || cmd_count == '0)
         cnt_load = CNT_ONE;
      else
         cnt_load = cmd_count;
   end

   // State register
   always_ff @(posedge clk or negedge RST) begin
      if (!RST)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   // Next state: stay in EXEC across back-to-back commands
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (accept) state_nxt = EXEC;
         EXEC: if (last) state_nxt = accept ? EXEC : IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Status outputs; ready is gated by reset so it reads 0 while held
   always_comb begin
      busy      = (state == EXEC);
      cmd_done  = last;
      cmd_ready = RST && ((state == IDLE) || last);
   end

   // Registered controls, operands, repeat counter and sticky error
   always_ff @(posedge clk or negedge RST) begin
      if (!RST) begin
         signal_load <= 1'b0;
         signal_init <= 1'b0;
         signal_neg  <= 1'b0;
         signal_oe   <= 1'b0;
         data_in_o   <= '0;
         attr_in_o   <= '0;
         cnt         <= '0;
         err         <= 1'b0;
      end else if (accept) begin
         signal_load <= dec_load;
         signal_init <= dec_init;
         signal_neg  <= dec_neg;
         signal_oe   <= dec_oe;
         data_in_o   <= dec_pass ? cmd_data : '0;
         attr_in_o   <= cmd_attr;
         cnt         <= cnt_load;
         if (dec_ill)
            err <= 1'b1;
      end else if (last) begin
         signal_load <= 1'b0;
         signal_init <= 1'b0;
         signal_neg  <= 1'b0;
         signal_oe   <= 1'b0;
         data_in_o   <= '0;
         cnt         <= '0;
      end else if (state == EXEC) begin
         cnt <= cnt - CNT_ONE;
      end
   end

endmodule

// File: tb/tb_bench_sequencer.sv
// tb_bench_sequencer: directed self-checking bench for bench_sequencer.
// Each task drives one scenario and checks outputs one tick after the edge.
module tb_bench_sequencer;

   logic       clk = 1'b0;
   logic       RST = 1'b0;
   logic       cmd_valid = 1'b0;
   logic       cmd_ready;
   logic [2:0] cmd_op = '0;
   logic [7:0] cmd_data = '0;
   logic [3:0] cmd_attr = '0;
   logic [7:0] cmd_count = '0;
   logic       signal_load, signal_init, signal_neg, signal_oe;
   logic [7:0] data_in_o;
   logic [3:0] attr_in_o;
   logic       busy, cmd_done, err;
   logic [3:0] ctrl;

   int errors = 0;
   int checks = 0;

   assign ctrl = {signal_load, signal_init, signal_neg, signal_oe};

   always #5 clk = ~clk;

   bench_sequencer #(
      .DATA_WIDTH(8),
      .ATTR_WIDTH(4),
      .CNT_WIDTH (8)
   ) dut (
      .clk        (clk),
      .RST        (RST),
      .cmd_valid  (cmd_valid),
      .cmd_ready  (cmd_ready),
      .cmd_op     (cmd_op),
      .cmd_data   (cmd_data),
      .cmd_attr   (cmd_attr),
      .cmd_count  (cmd_count),
      .signal_load(signal_load),
      .signal_init(signal_init),
      .signal_neg (signal_neg),
      .signal_oe  (signal_oe),
      .data_in_o  (data_in_o),
      .attr_in_o  (attr_in_o),
      .busy       (busy),
      .cmd_done   (cmd_done),
      .err        (err)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load_cmd(input logic [2:0] op, input logic [7:0] d,
                           input logic [3:0] a, input logic [7:0] c);
      cmd_op    = op;
      cmd_data  = d;
      cmd_attr  = a;
      cmd_count = c;
   endtask

   // issue one command from idle; returns in its first execution cycle
   task automatic send(input logic [2:0] op, input logic [7:0] d,
                       input logic [3:0] a, input logic [7:0] c);
      load_cmd(op, d, a, c);
      cmd_valid = 1'b1;
      tick();
      cmd_valid = 1'b0;
   endtask

   task automatic test_reset();
      RST = 1'b0;
      #20;
      checks++;
      if ({ctrl, busy, cmd_done, cmd_ready, err} !== 8'h00) begin
         errors++;
         $display("FAIL reset_flags: got %b expected 00000000",
                  {ctrl, busy, cmd_done, cmd_ready, err});
      end
      checks++;
      if (data_in_o !== 8'd0 || attr_in_o !== 4'd0) begin
         errors++;
         $display("FAIL reset_data: got %0d/%0d expected 0/0",
                  data_in_o, attr_in_o);
      end
      @(negedge clk);
      RST = 1'b1;
      #1;
      checks++;
      if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
         errors++;
         $display("FAIL reset_release: got ready=%b busy=%b expected 1 0",
                  cmd_ready, busy);
      end
      tick();
   endtask

   task automatic test_init();
      send(3'd1, 8'd25, 4'd3, 8'd1);
      checks++;
      if (ctrl !== 4'b1100 || data_in_o !== 8'd25 || attr_in_o !== 4'd3) begin
         errors++;
         $display("FAIL init_out: got %b/%0d/%0d expected 1100/25/3",
                  ctrl, data_in_o, attr_in_o);
      end
      checks++;
      if ({busy, cmd_done, cmd_ready} !== 3'b111) begin
         errors++;
         $display("FAIL init_status: got %b expected 111",
                  {busy, cmd_done, cmd_ready});
      end
      tick();
      checks++;
      if (ctrl !== 4'b0000 || data_in_o !== 8'd0 || busy !== 1'b0
          || attr_in_o !== 4'd3) begin
         errors++;
         $display("FAIL init_after: got %b/%0d/%b/%0d expected 0000/0/0/3",
                  ctrl, data_in_o, busy, attr_in_o);
      end
   endtask

   task automatic test_multi();
      send(3'd1, 8'd5, 4'd2, 8'd2);
      checks++;
      if (ctrl !== 4'b1100 || data_in_o !== 8'd5
          || {busy, cmd_done, cmd_ready} !== 3'b100) begin
         errors++;
         $display("FAIL multi_c1: got %b/%0d/%b expected 1100/5/100",
                  ctrl, data_in_o, {busy, cmd_done, cmd_ready});
      end
      tick();
      checks++;
      if (ctrl !== 4'b1100 || data_in_o !== 8'd5
          || {busy, cmd_done, cmd_ready} !== 3'b111) begin
         errors++;
         $display("FAIL multi_c2: got %b/%0d/%b expected 1100/5/111",
                  ctrl, data_in_o, {busy, cmd_done, cmd_ready});
      end
      tick();
      checks++;
      if (ctrl !== 4'b0000 || busy !== 1'b0) begin
         errors++;
         $display("FAIL multi_end: got %b/%b expected 0000/0", ctrl, busy);
      end
   endtask

   task automatic test_back_to_back();
      logic [2:0] ops [4] = '{3'd1, 3'd2, 3'd0, 3'd4};
      logic [7:0] dat [4] = '{8'd25, 8'd25, 8'h77, 8'h66};
      logic [7:0] cnt [4] = '{8'd1, 8'd1, 8'd10, 8'd10};
      logic [3:0] exp_ctrl;
      logic [7:0] exp_data;
      logic       acc;
      int         idx = 0;
      int         dones = 0;
      load_cmd(ops[0], dat[0], 4'd0, cnt[0]);
      cmd_valid = 1'b1;
      for (int cyc = 0; cyc < 22; cyc++) begin
         acc = cmd_ready;
         tick();
         if (acc) begin
            idx++;
            if (idx < 4)
               load_cmd(ops[idx], dat[idx], 4'd0, cnt[idx]);
            else
               cmd_valid = 1'b0;
         end
         exp_ctrl = (cyc < 1) ? 4'b1100 : (cyc < 2) ? 4'b1000 :
                    (cyc < 12) ? 4'b0000 : 4'b0001;
         exp_data = (cyc < 2) ? 8'd25 : 8'd0;
         checks++;
         if (ctrl !== exp_ctrl || busy !== 1'b1 || data_in_o !== exp_data) begin
            errors++;
            $display("FAIL b2b_cyc%0d: got %b/%b/%0d expected %b/1/%0d",
                     cyc, ctrl, busy, data_in_o, exp_ctrl, exp_data);
         end
         if (cmd_done === 1'b1)
            dones++;
      end
      cmd_valid = 1'b0;
      checks++;
      if (dones != 4 || idx != 4) begin
         errors++;
         $display("FAIL b2b_done: got dones=%0d accepts=%0d expected 4 4",
                  dones, idx);
      end
      tick();
      checks++;
      if (busy !== 1'b0 || ctrl !== 4'b0000) begin
         errors++;
         $display("FAIL b2b_end: got %b/%b expected 0/0000", busy, ctrl);
      end
   endtask

   task automatic test_illegal();
      load_cmd(3'd7, 8'd9, 4'd5, 8'd20);
      cmd_valid = 1'b1;
      tick();
      checks++;
      if (ctrl !== 4'b0000 || data_in_o !== 8'd0 || attr_in_o !== 4'd5
          || {busy, cmd_done, cmd_ready, err} !== 4'b1111) begin
         errors++;
         $display("FAIL illegal_exec: got %b/%0d/%0d/%b expected 0000/0/5/1111",
                  ctrl, data_in_o, attr_in_o, {busy, cmd_done, cmd_ready, err});
      end
      load_cmd(3'd5, 8'd3, 4'd1, 8'd1);
      tick();
      cmd_valid = 1'b0;
      checks++;
      if (ctrl !== 4'b1010 || data_in_o !== 8'd3 || attr_in_o !== 4'd1
          || busy !== 1'b1 || err !== 1'b1) begin
         errors++;
         $display("FAIL loadneg: got %b/%0d/%0d/%b/%b expected 1010/3/1/1/1",
                  ctrl, data_in_o, attr_in_o, busy, err);
      end
      tick();
      checks++;
      if (busy !== 1'b0 || err !== 1'b1 || attr_in_o !== 4'd1) begin
         errors++;
         $display("FAIL illegal_after: got %b/%b/%0d expected 0/1/1",
                  busy, err, attr_in_o);
      end
   endtask

   task automatic test_count_edges();
      int n = 0;
      send(3'd4, 8'h12, 4'd0, 8'd0);
      checks++;
      if (ctrl !== 4'b0001 || data_in_o !== 8'd0 || cmd_done !== 1'b1) begin
         errors++;
         $display("FAIL out_c0: got %b/%0d/%b expected 0001/0/1",
                  ctrl, data_in_o, cmd_done);
      end
      tick();
      checks++;
      if (ctrl !== 4'b0000 || busy !== 1'b0) begin
         errors++;
         $display("FAIL out_c0_end: got %b/%b expected 0000/0", ctrl, busy);
      end
      send(3'd4, 8'd0, 4'd0, 8'd255);
      for (int i = 0; i < 300; i++) begin
         if (signal_oe === 1'b1)
            n++;
         if (busy !== 1'b1)
            break;
         tick();
      end
      checks++;
      if (n != 255 || busy !== 1'b0) begin
         errors++;
         $display("FAIL out_c255: got oe_cycles=%0d busy=%b expected 255 0",
                  n, busy);
      end
      checks++;
      if (err !== 1'b1) begin
         errors++;
         $display("FAIL err_sticky: got %b expected 1", err);
      end
   endtask

   task automatic test_reset_mid();
      send(3'd4, 8'd0, 4'd6, 8'd10);
      tick();
      tick();
      tick();
      checks++;
      if (signal_oe !== 1'b1 || busy !== 1'b1) begin
         errors++;
         $display("FAIL mid_pre: got oe=%b busy=%b expected 1 1",
                  signal_oe, busy);
      end
      RST = 1'b0;
      #1;
      checks++;
      if ({ctrl, busy, cmd_ready, err} !== 7'b0 || attr_in_o !== 4'd0) begin
         errors++;
         $display("FAIL mid_reset: got %b/%0d expected 0000000/0",
                  {ctrl, busy, cmd_ready, err}, attr_in_o);
      end
      #2;
      RST = 1'b1;
      #1;
      checks++;
      if (cmd_ready !== 1'b1 || busy !== 1'b0 || signal_oe !== 1'b0) begin
         errors++;
         $display("FAIL mid_release: got %b/%b/%b expected 1/0/0",
                  cmd_ready, busy, signal_oe);
      end
      tick();
      checks++;
      if (busy !== 1'b0 || signal_oe !== 1'b0) begin
         errors++;
         $display("FAIL mid_noresume: got %b/%b expected 0/0",
                  busy, signal_oe);
      end
   endtask

   initial begin
      test_reset();
      test_init();
      test_multi();
      test_back_to_back();
      test_illegal();
      test_count_edges();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/bench_sequencer.md
BENCH_SEQUENCER -- requirements
Module: bench_sequencer

Interface
REQ-001 The module SHALL have parameter DATA_WIDTH, default 8, width of the data word sent to the accumulator unit.
REQ-002 The module SHALL have parameter ATTR_WIDTH, default 4, width of the attribute word.
REQ-003 The module SHALL have parameter CNT_WIDTH, default 8, width of the command repeat count.
REQ-004 The module SHALL have ports:
- clk  input  1  rising-edge clock, only clock
- RST  input  1  asynchronous, active-low reset (0 = reset)
- cmd_valid  input  1  command present
- cmd_ready  output  1  command accepted when cmd_valid && cmd_ready at the clk edge
- cmd_op  input  3  operation code
- cmd_data  input  DATA_WIDTH  data operand
- cmd_attr  input  ATTR_WIDTH  attribute operand
- cmd_count  input  CNT_WIDTH  execution cycles (0 treated as 1)
- signal_load, signal_init, signal_neg, signal_oe  output  1 each  registered controls to the downstream unit
- data_in_o  output  DATA_WIDTH  registered data to the unit's data_in
- attr_in_o  output  ATTR_WIDTH  registered attribute to the unit's attr_in
- busy  output  1  command executing
- cmd_done  output  1  high during the final execution cycle of each command
- err  output  1  sticky illegal-opcode flag

Function
REQ-005 The opcode map SHALL be: 0 NOP (all controls 0); 1 INIT (load=1, init=1); 2 LOAD (load=1); 3 NEG (neg=1); 4 OUT (oe=1); 5 LOADNEG (load=1, neg=1); 6–7 illegal.
REQ-006 The FSM SHALL have two states: IDLE and EXEC.
REQ-007 cmd_ready SHALL be 1 in IDLE, 1 in EXEC when the remaining count is 1, and 0 otherwise.
REQ-008 A command accepted at edge N SHALL drive its control pattern on the outputs during cycles N+1 through N+max(cmd_count,1); no output combinational path from cmd_* SHALL exist.
REQ-009 A command accepted during the final EXEC cycle SHALL begin on the immediately following cycle with no idle gap (back-to-back).
REQ-010 If no command is accepted in the final EXEC cycle, the FSM SHALL return to IDLE with all four controls and data_in_o at 0 in the next cycle.
REQ-011 data_in_o SHALL equal cmd_data for INIT/LOAD/NEG/LOADNEG; it SHALL be 0 for NOP, OUT, and illegal opcodes.
REQ-012 attr_in_o SHALL update to cmd_attr on every accepted command and hold between commands.
REQ-013 The remaining-count register SHALL load max(cmd_count,1) on accept, decrement once per EXEC cycle, and never wrap below 1; cmd_count = 2^CNT_WIDTH-1 SHALL run exactly that many cycles.
REQ-014 busy SHALL be 1 in EXEC and 0 in IDLE; cmd_done SHALL be 1 exactly in the cycle where the remaining count is 1.
REQ-015 Illegal opcodes SHALL be accepted, executed as a single-cycle NOP regardless of cmd_count, and set err; err SHALL clear only on reset.
REQ-016 cmd_valid deasserted, or changes to cmd_* while cmd_ready=0, SHALL have no effect.

Reset
REQ-017 While RST=0 the module SHALL, asynchronously, force IDLE, count 0, and all outputs to 0, including cmd_ready, data_in_o, attr_in_o, and err.
REQ-018 Reset asserted mid-command SHALL abort the command with no resumption; cmd_ready SHALL be 1 in the first cycle after RST rises.

Verification
REQ-019 Reset → all outputs 0; release RST, then INIT data=25 count=1 → load=init=1, data_in_o=25 for exactly 1 cycle; then 0 with busy=0.
REQ-020 Back-to-back INIT 25 c=1, LOAD 25 c=1, NOP c=10, OUT c=10 with cmd_valid held → 1+1+10+10 contiguous cycles, oe=1 only in the last 10, cmd_done pulses 4 times.
REQ-021 INIT 5 count=2 → load=init=1 and data_in_o=5 for 2 cycles, cmd_ready=1 only in the 2nd cycle.
REQ-022 cmd_op=7 count=20 → 1 cycle all controls 0, err=1 persisting until reset; a following LOADNEG 3 c=1 → load=neg=1, data_in_o=3.
REQ-023 OUT count=0 → oe=1 for exactly 1 cycle; OUT count=255 → oe=1 for 255 cycles.
REQ-024 RST low in the 4th cycle of OUT count=10 → oe drops immediately (asynchronously); after release: cmd_ready=1, busy=0, oe=0.
